// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the digit-serial subtractor:
//   state_t     - controller state encoding (IDLE, RUN, DONE)
//   num_digits  - number of digit steps per operation (WIDTH / DIGIT)
//   cnt_width   - width of the digit counter, never less than 1 bit
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // $clog2(1) is 0, so a single-digit operation still gets a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// -----------------------------------------------------------------------------
// digit_subtractor
// Combinational DIGIT-bit subtractor built as a ripple of full-subtractor
// cells: diff = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
// Ports:
//   a, b  [DIGIT-1:0]  digit operands (a - b)
//   bin               borrow into the least significant cell
//   diff  [DIGIT-1:0]  digit difference
//   bout              borrow out of the most significant cell
// -----------------------------------------------------------------------------
module digit_subtractor #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             bin,
   output logic [DIGIT-1:0] diff,
   output logic             bout
);

   // Running borrow is a scalar walked through the loop rather than a vector,
   // so each cell sees the borrow produced by the cell below it.
   logic borrow_chain;

   always_comb begin
      diff         = '0;
      borrow_chain = bin;
      for (int i = 0; i < DIGIT; i++) begin
         diff[i]      = a[i] ^ b[i] ^ borrow_chain;
         borrow_chain = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_chain);
      end
      bout = borrow_chain;
   end

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Multi-cycle A - B - Bin, one DIGIT-bit slice per clock, LSB first, with a
// borrow flop carried between slices. Results are registered and only change
// at completion.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             operation request, sampled only in IDLE
//   A, B [WIDTH-1:0]  minuend / subtrahend, captured on accepted start
//   Bin               borrow-in, captured on accepted start
//   busy              high in RUN and DONE
//   done              one-cycle pulse, results updated this cycle
//   Difference        A - B - Bin modulo 2^WIDTH
//   Borrow            borrow out of the MSB
//   Overflow          two's-complement overflow of the signed subtraction
//   state             current controller state (debug observation)
//
// Handshake: start is a request with no acknowledge. It is accepted at a
// rising edge only when the controller is in IDLE; in RUN or DONE it is
// ignored and not remembered. Completion is signalled by done for exactly one
// cycle; Difference/Borrow/Overflow stay stable until the next done.
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Difference,
   output logic             Borrow,
   output logic             Overflow,
   output state_t           state
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and divisible by DIGIT");
   end

   state_t           state_q;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             borrow_q;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;
   logic [DIGIT-1:0] d_diff;
   logic             d_bout;

   assign state = state_q;

   digit_subtractor #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sr[DIGIT-1:0]),
      .b    (b_sr[DIGIT-1:0]),
      .bin  (borrow_q),
      .diff (d_diff),
      .bout (d_bout)
   );

   // New digit enters from the MSB side; after N steps the first digit has
   // travelled down to bit 0 and the register holds the full result.
   if (DIGIT == WIDTH) begin : g_single
      assign res_next = d_diff;
   end else begin : g_multi
      assign res_next = {d_diff, res_sr[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow_q   <= 1'b0;
         cnt        <= '0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         Difference <= '0;
         Borrow     <= 1'b0;
         Overflow   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr     <= A;
                  b_sr     <= B;
                  borrow_q <= Bin;
                  a_msb    <= A[WIDTH-1];
                  b_msb    <= B[WIDTH-1];
                  res_sr   <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               res_sr   <= res_next;
               borrow_q <= d_bout;
               a_sr     <= a_sr >> DIGIT;
               b_sr     <= b_sr >> DIGIT;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) begin
                  Difference <= res_next;
                  Borrow     <= d_bout;
                  // Signed overflow only when operand signs differ and the
                  // result sign disagrees with the minuend.
                  Overflow   <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
                  done       <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Three instances (DIGIT = 1, 4, 8 at WIDTH = 8) share clock, reset and
// operand inputs. Directed vectors with hand-computed results, a random sweep
// against an arithmetic reference, start-ignore, back-to-back and mid-run
// reset scenarios.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic Bin   = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;

   always #5 clk = ~clk;

   logic busy1, done1, bor1, ovf1;
   logic busy4, done4, bor4, ovf4;
   logic busy8, done8, bor8, ovf8;
   logic [7:0] diff1, diff4, diff8;
   state_t st1, st4, st8;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
      .busy(busy1), .done(done1), .Difference(diff1), .Borrow(bor1),
      .Overflow(ovf1), .state(st1));

   serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
      .busy(busy4), .done(done4), .Difference(diff4), .Borrow(bor4),
      .Overflow(ovf4), .state(st4));

   serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
      .busy(busy8), .done(done8), .Difference(diff8), .Borrow(bor8),
      .Overflow(ovf8), .state(st8));

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_err    = 0;
   int n_done1  = 0;
   int n_done4  = 0;
   int n_done8  = 0;

   always @(negedge clk) begin
      if (done1) n_done1++;
      if (done4) n_done4++;
      if (done8) n_done8++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, borrow, difference} from plain integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      logic [8:0] w;
      int sr;
      w  = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
      return {(sr > 127 || sr < -128), w[8], w[7:0]};
   endfunction

   // ---------------- driver ----------------
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb, input logic eo);
      int l1, l4, l8, c1, c4, c8;
      logic [7:0] d1, d4, d8;
      logic r1, r4, r8, v1, v4, v8;
      l1 = 0; l4 = 0; l8 = 0;
      d1 = '0; d4 = '0; d8 = '0;
      r1 = 0; r4 = 0; r8 = 0; v1 = 0; v4 = 0; v8 = 0;
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      c1 = n_done1; c4 = n_done4; c8 = n_done8;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble inputs after capture; results must not depend on them.
      A = ~a; B = ~b; Bin = ~bin;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (done1 && l1 == 0) begin l1 = c; d1 = diff1; r1 = bor1; v1 = ovf1; end
         if (done4 && l4 == 0) begin l4 = c; d4 = diff4; r4 = bor4; v4 = ovf4; end
         if (done8 && l8 == 0) begin l8 = c; d8 = diff8; r8 = bor8; v8 = ovf8; end
      end
      chk({tag, "/lat1"}, l1, 8);
      chk({tag, "/lat4"}, l4, 2);
      chk({tag, "/lat8"}, l8, 1);
      chk({tag, "/diff1"}, d1, ed);
      chk({tag, "/diff4"}, d4, ed);
      chk({tag, "/diff8"}, d8, ed);
      chk({tag, "/bor1"}, r1, eb);
      chk({tag, "/bor4"}, r4, eb);
      chk({tag, "/bor8"}, r8, eb);
      chk({tag, "/ovf1"}, v1, eo);
      chk({tag, "/ovf4"}, v4, eo);
      chk({tag, "/ovf8"}, v8, eo);
      chk({tag, "/ndone1"}, n_done1 - c1, 1);
      chk({tag, "/ndone4"}, n_done4 - c4, 1);
      chk({tag, "/ndone8"}, n_done8 - c8, 1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int c1, c4, c8, f1, s1, f4, s4;
      logic [9:0] m;
      logic [7:0] ra, rb;
      logic rbin;

      // Reset state
      #2;
      chk("rst/busy1", busy1, 0);
      chk("rst/done1", done1, 0);
      chk("rst/diff1", diff1, 0);
      chk("rst/bor1", bor1, 0);
      chk("rst/ovf1", ovf1, 0);
      chk("rst/state1", st1, IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Hand-computed vectors
      do_op("v05_03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      do_op("v03_05",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      do_op("v00_00_1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op("v80_01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      do_op("v7F_FF",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      do_op("vFF_FF_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op("v80_00_1", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

      // Random sweep against the arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         m    = model(ra, rb, rbin);
         do_op($sformatf("rnd%0d", i), ra, rb, rbin, m[7:0], m[8], m[9]);
      end

      // Start during RUN (DIGIT=1) and during DONE (DIGIT=4) is ignored;
      // DIGIT=8 is already idle again and accepts the second request.
      c1 = n_done1; c4 = n_done4; c8 = n_done8;
      @(negedge clk);
      A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      A = 8'h55; B = 8'h22; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; A = 8'h00; B = 8'h00;
      repeat (12) @(posedge clk);
      #1;
      chk("ign/diff1", diff1, 8'h0F);
      chk("ign/ndone1", n_done1 - c1, 1);
      chk("ign/diff4", diff4, 8'h0F);
      chk("ign/ndone4", n_done4 - c4, 1);
      chk("ign/diff8", diff8, 8'h33);
      chk("ign/ndone8", n_done8 - c8, 2);

      // Start held high: re-accepted every N+2 cycles
      f1 = -1; s1 = -1; f4 = -1; s4 = -1;
      @(negedge clk);
      A = 8'h20; B = 8'h01; Bin = 1'b0; start = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (done1) begin if (f1 < 0) f1 = c; else if (s1 < 0) s1 = c; end
         if (done4) begin if (f4 < 0) f4 = c; else if (s4 < 0) s4 = c; end
      end
      start = 1'b0;
      chk("b2b/first1", f1, 8);
      chk("b2b/gap1", s1 - f1, 10);
      chk("b2b/first4", f4, 2);
      chk("b2b/gap4", s4 - f4, 4);
      repeat (14) @(posedge clk);
      #1;
      chk("b2b/diff1", diff1, 8'h1F);

      // Mid-run reset: leave non-zero results first, then abort at RUN cycle 3
      do_op("pre_rst", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      c1 = n_done1;
      @(negedge clk);
      A = 8'h09; B = 8'h04; Bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid/state_before", st1, RUN);
      rst = 1'b1;
      #1;
      chk("mid/busy1", busy1, 0);
      chk("mid/done1", done1, 0);
      chk("mid/diff1", diff1, 0);
      chk("mid/bor1", bor1, 0);
      chk("mid/ovf1", ovf1, 0);
      chk("mid/state1", st1, IDLE);
      chk("mid/diff4", diff4, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("mid/no_done1", n_done1 - c1, 0);
      chk("mid/diff1_hold", diff1, 0);
      do_op("post_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
